avg_sample_sequencer: RTL

Sequencer for the lock-in moving-average filter. Generates the sample-enable strobe (cnt_clk) at a programmable decimation rate and drives the averager's active-low clear. Tracks filter settling after every clear and flags when the averaged output is trustworthy. Applies sample-rate reconfiguration glitch-free: a rate change always clears and re-settles the averager.

---
 rtl/avg_sample_sequencer.sv | 184 ++++++++++++++++++
 1 files changed

// File: rtl/avg_sample_sequencer.sv
// Sequencer for the lock-in moving-average filter: decimated sample strobe,
// averager clear, settling tracking and glitch-free sample-rate reconfiguration.
module avg_sample_sequencer #(
  parameter int unsigned DIV_BITS       = 16,
  parameter int unsigned DEFAULT_DIV    = 99,
  parameter int unsigned LOG2_SAMPLES   = 8,
  parameter int unsigned SETTLE_TC_LOG2 = 2,
  parameter int unsigned CLEAR_CYCLES   = 2
) (
  input  logic                                     clk_i,
  input  logic                                     rst_ni,
  input  logic                                     enable_i,
  input  logic                                     hold_i,
  input  logic [DIV_BITS-1:0]                      cfg_div_i,
  input  logic                                     cfg_load_i,
  output logic                                     cfg_ack_o,
  output logic                                     cnt_clk_o,
  output logic                                     avg_rst_o,
  output logic                                     out_valid_o,
  output logic [LOG2_SAMPLES+SETTLE_TC_LOG2:0]     settle_cnt_o,
  output logic [1:0]                               state_o
);

  localparam int unsigned SC_W  = LOG2_SAMPLES + SETTLE_TC_LOG2 + 1;
  localparam int unsigned CLR_W = (CLEAR_CYCLES > 1) ? $clog2(CLEAR_CYCLES) : 1;
  localparam logic [SC_W-1:0]  SETTLE_TERM = {1'b1, {(SC_W-1){1'b0}}};
  localparam logic [CLR_W-1:0] CLR_LAST    = CLR_W'(CLEAR_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_CLEAR  = 2'd1,
    ST_SETTLE = 2'd2,
    ST_VALID  = 2'd3
  } state_e;

  // A divider of 0 would keep the strobe permanently high; the averager needs an edge.
  function automatic logic [DIV_BITS-1:0] clamp_div(input logic [DIV_BITS-1:0] v);
    return (v == '0) ? DIV_BITS'(1) : v;
  endfunction

  state_e              state_q, state_d;
  logic [DIV_BITS-1:0] div_cnt_q, div_cnt_d;
  logic [DIV_BITS-1:0] div_reg_q, div_reg_d;
  logic [DIV_BITS-1:0] pend_val_q, pend_val_d;
  logic                pend_q, pend_d;
  logic [CLR_W-1:0]    clr_cnt_q, clr_cnt_d;
  logic [SC_W-1:0]     settle_cnt_q, settle_cnt_d;
  logic                cnt_clk_q, avg_rst_q, out_valid_q, cfg_ack_q;
  logic                apply_s, strobe_s, tc_s;

  assign tc_s = (div_cnt_q == div_reg_q);

  // Next-state, divider, settling counter and pending-config logic.
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = '0;
    settle_cnt_d = settle_cnt_q;
    clr_cnt_d    = clr_cnt_q;
    div_reg_d    = div_reg_q;
    pend_d       = pend_q;
    pend_val_d   = pend_val_q;
    apply_s      = 1'b0;
    strobe_s     = 1'b0;

    case (state_q)
      ST_IDLE: begin
        clr_cnt_d    = '0;
        settle_cnt_d = '0;
        apply_s      = pend_q;
        if (enable_i) begin
          state_d = ST_CLEAR;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_CLEAR: begin
        settle_cnt_d = '0;
        if (!enable_i) begin
          state_d   = ST_IDLE;
          clr_cnt_d = '0;
        end else if (pend_q) begin
          apply_s   = 1'b1;
          clr_cnt_d = '0;
        end else if (clr_cnt_q == CLR_LAST) begin
          state_d   = ST_SETTLE;
          clr_cnt_d = '0;
        end else begin
          clr_cnt_d = clr_cnt_q + CLR_W'(1);
        end
      end
      ST_SETTLE, ST_VALID: begin
        if (!enable_i) begin
          state_d      = ST_IDLE;
          settle_cnt_d = '0;
        end else begin
          div_cnt_d = tc_s ? '0 : div_cnt_q + DIV_BITS'(1);
          if (tc_s && !hold_i) begin
            strobe_s = 1'b1;
            if (settle_cnt_q != SETTLE_TERM) begin
              settle_cnt_d = settle_cnt_q + SC_W'(1);
            end else begin
              settle_cnt_d = settle_cnt_q;
            end
          end else begin
            settle_cnt_d = settle_cnt_q;
          end
          // The period's strobe still goes out, then the rate change re-clears.
          if (tc_s && pend_q) begin
            apply_s      = 1'b1;
            state_d      = ST_CLEAR;
            div_cnt_d    = '0;
            settle_cnt_d = '0;
          end else if ((state_q == ST_SETTLE) && (settle_cnt_q == SETTLE_TERM)) begin
            state_d = ST_VALID;
          end else begin
            state_d = state_q;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (apply_s) begin
      div_reg_d = clamp_div(pend_val_q);
      pend_d    = 1'b0;
    end else begin
      div_reg_d = div_reg_q;
    end

    // A write coincident with an apply is kept for the following apply point.
    if (cfg_load_i) begin
      pend_d     = 1'b1;
      pend_val_d = cfg_div_i;
    end else begin
      pend_val_d = pend_val_q;
    end
  end

  // State, counters and configuration registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q      <= ST_IDLE;
      div_cnt_q    <= '0;
      div_reg_q    <= clamp_div(DIV_BITS'(DEFAULT_DIV));
      pend_val_q   <= '0;
      pend_q       <= 1'b0;
      clr_cnt_q    <= '0;
      settle_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      div_cnt_q    <= div_cnt_d;
      div_reg_q    <= div_reg_d;
      pend_val_q   <= pend_val_d;
      pend_q       <= pend_d;
      clr_cnt_q    <= clr_cnt_d;
      settle_cnt_q <= settle_cnt_d;
    end
  end

  // Registered strobe, clear, valid and acknowledge outputs.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_clk_q   <= 1'b0;
      avg_rst_q   <= 1'b0;
      out_valid_q <= 1'b0;
      cfg_ack_q   <= 1'b0;
    end else begin
      cnt_clk_q   <= strobe_s;
      avg_rst_q   <= (state_d == ST_SETTLE) || (state_d == ST_VALID);
      out_valid_q <= (state_d == ST_VALID);
      cfg_ack_q   <= apply_s;
    end
  end

  assign cnt_clk_o    = cnt_clk_q;
  assign avg_rst_o    = avg_rst_q;
  assign out_valid_o  = out_valid_q;
  assign cfg_ack_o    = cfg_ack_q;
  assign settle_cnt_o = settle_cnt_q;
  assign state_o      = state_q;

endmodule
